// File: rtl/if_fetch_unit_pkg.sv
//------------------------------------------------------------------------------
// Module      : if_fetch_unit_pkg
// Description : Shared constants, the prefetch entry type and a PC alignment
//               helper for the instruction-fetch stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package if_fetch_unit_pkg;

  // Default first fetch address after reset
  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;
  // Bubble encoding presented downstream when no instruction is available
  localparam logic [31:0] C_NOP      = 32'h0000_0000;
  // Sequential fetch increment (one 32-bit word)
  localparam logic [31:0] C_PC_STEP  = 32'd4;

  // One prefetch FIFO entry: instruction word tagged with its PC
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Word-align an address by clearing the byte-offset bits
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_sync_fifo.sv
//------------------------------------------------------------------------------
// Module      : if_fetch_unit_sync_fifo
// Description : Synchronous FIFO with registered push/pop, a synchronous
//               flush, an occupancy count and a combinational head output.
//               DEPTH must be a power of two so the pointers wrap naturally.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int              PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_r;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_r == '0);
  assign full    = (count_r == DEPTH_CNT);
  assign count   = count_r;
  assign head    = mem[rd_ptr];

  // Popping an empty FIFO is ignored; a push into a full FIFO only lands
  // when the same cycle frees a slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the FIFO in one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count_r <= count_r + 1'b1;
      else if (do_pop && !do_push) count_r <= count_r - 1'b1;
    end
  end

  // Storage array; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // A push that cannot land means the upstream issue guard is broken
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && full && !do_pop));

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : if_fetch_unit
// Description : Instruction-fetch stage. Issues in-order word fetches to a
//               variable-latency instruction memory, buffers returned words
//               with their PCs in a prefetch FIFO and presents the FIFO head
//               to IF/ID. Redirects flush the FIFO and discard responses
//               still in flight on the old path. rst is active-low, async.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = C_RESET_PC,
  parameter int          FIFO_DEPTH = 4,
  parameter int          CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [31:0] jb_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        inst_valid,
  output logic        if_empty
);

  localparam logic [CNT_W:0] DEPTH_W = (CNT_W + 1)'(FIFO_DEPTH);

  logic [31:0]      fetch_pc;      // next address to request
  logic [31:0]      resp_pc;       // PC of the next kept response
  logic [CNT_W-1:0] outstanding;   // accepted requests awaiting data
  logic [CNT_W-1:0] drop_cnt;      // responses still owed to the old path
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   in_use;
  logic [CNT_W-1:0] out_after_resp;
  logic             accept;
  logic             dropping;
  logic             keep;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic             fifo_full;
  logic [63:0]      head_bits;
  fetch_entry_t     head;
  fetch_entry_t     push_entry;
  logic [31:0]      redirect_pc;

  // Only issue while every request already in flight plus the buffered
  // entries still leaves a free slot, so a kept response always fits.
  assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imem_req  = rst && !jb && (in_use < DEPTH_W);
  assign imem_addr = fetch_pc;
  assign accept    = imem_req && imem_ready;

  assign dropping  = imem_rvalid && (drop_cnt != '0);
  assign keep      = imem_rvalid && (drop_cnt == '0);
  assign push      = keep && !jb;
  assign pop       = inst_valid && !stall && !jb;

  // A redirect never coincides with an accept (imem_req is low), so only
  // the response decrement needs folding into the surviving count.
  assign out_after_resp = outstanding - {{(CNT_W-1){1'b0}}, imem_rvalid};
  assign redirect_pc    = align_word(jb_target);

  assign push_entry.pc   = resp_pc;
  assign push_entry.inst = imem_rdata;

  // Fetch and response PCs: advance on accept/kept response, reload on redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (jb) begin
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
    end else begin
      if (accept) fetch_pc <= fetch_pc + C_PC_STEP;
      if (keep)   resp_pc  <= resp_pc + C_PC_STEP;
    end
  end

  // In-flight and drop counters; a redirect marks everything still out as stale
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (jb) begin
      outstanding <= out_after_resp;
      drop_cnt    <= out_after_resp;
    end else begin
      outstanding <= out_after_resp + {{(CNT_W-1){1'b0}}, accept};
      if (dropping) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  if_fetch_unit_sync_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .flush (jb),
    .push  (push),
    .din   (push_entry),
    .pop   (pop),
    .head  (head_bits),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head       = fetch_entry_t'(head_bits);
  assign inst_valid = !fifo_empty;
  assign if_empty   = fifo_empty;
  assign pc_out     = inst_valid ? head.pc   : C_NOP;
  assign inst_out   = inst_valid ? head.inst : C_NOP;

  // The issue guard must keep buffered plus in-flight within the FIFO size
  a_guard_holds : assert property (@(posedge clk) disable iff (!rst)
    in_use <= DEPTH_W);

  // Memory must never answer a request that was not issued
  a_no_orphan_resp : assert property (@(posedge clk) disable iff (!rst)
    !(imem_rvalid && outstanding == '0));

  // A kept response always finds room
  a_kept_fits : assert property (@(posedge clk) disable iff (!rst)
    !(push && fifo_full && !pop));

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit with an
//               in-order variable-latency instruction memory model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        jb = 1'b0;
  logic [31:0] jb_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        inst_valid;
  logic        if_empty;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  logic [31:0] exp_pc = 32'h0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t mem_q[$];

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .jb          (jb),
    .jb_target   (jb_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc_out      (pc_out),
    .inst_out    (inst_out),
    .inst_valid  (inst_valid),
    .if_empty    (if_empty)
  );

  // Memory contents: a recognisable word derived from the address
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Present the oldest pending response once its latency has elapsed
  task automatic drive_mem();
    if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
      imem_rvalid = 1'b1;
      imem_rdata  = inst_of(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  // One clock: check the head stream, advance memory model and head tracker
  task automatic step();
    logic        acc;
    logic        rsp;
    logic        popped;
    logic [31:0] a;
    #1;
    acc    = imem_req && imem_ready;
    rsp    = imem_rvalid;
    a      = imem_addr;
    popped = inst_valid && !stall && !jb;
    if (!jb) begin
      if (inst_valid) begin
        chk("head_pc", pc_out, exp_pc);
        chk("head_inst", inst_out, inst_of(exp_pc));
      end else begin
        chk("bubble_pc", pc_out, 32'h0);
        chk("bubble_inst", inst_out, 32'h0);
      end
    end
    @(posedge clk);
    cyc++;
    if (rsp) void'(mem_q.pop_front());
    if (acc) mem_q.push_back('{addr: a, due: cyc + lat});
    if (jb)          exp_pc = {jb_target[31:2], 2'b00};
    else if (popped) exp_pc = exp_pc + 32'd4;
    @(negedge clk);
    drive_mem();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   imem_req,   32'h0);
    chk({tag, "_addr"},  imem_addr,  32'h0);
    chk({tag, "_pc"},    pc_out,     32'h0);
    chk({tag, "_inst"},  inst_out,   32'h0);
    chk({tag, "_valid"}, inst_valid, 32'h0);
    chk({tag, "_empty"}, if_empty,   32'h1);
  endtask

  // Assert reset at a negedge, check outputs respond at once, then release
  task automatic do_reset(input int new_lat);
    rst = 1'b0;
    stall = 1'b0;
    jb = 1'b0;
    imem_ready = 1'b0;
    mem_q.delete();
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    #1;
    check_reset_outputs("rst_now");
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b1;
    cyc = 0;
    exp_pc = 32'h0;
    lat = new_lat;
  endtask

  // Step until the head becomes valid; returns the number of steps taken
  task automatic wait_valid(input string tag, input int limit, output int n);
    n = 0;
    while (!inst_valid && n < limit) begin
      step();
      n++;
    end
    if (!inst_valid) chk({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  initial begin
    int n;
    @(negedge clk);

    // 1: back-to-back stream at latency 1
    do_reset(1);
    imem_ready = 1'b1;
    chk("t1_addr0", imem_addr, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("t1_addr", imem_addr, 32'(4 * k));
      if (k >= 2) chk("t1_valid", inst_valid, 32'h1);
      if (k == 2) chk("t1_first_pc", pc_out, 32'h0);
      if (k == 3) chk("t1_second_pc", pc_out, 32'h4);
    end

    // 2: stall fills the FIFO, issue stops, release drains without loss
    do_reset(1);
    imem_ready = 1'b1;
    repeat (4) step();
    chk("t2_head_pre", pc_out, 32'h8);
    stall = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t2_req", imem_req, (k == 1) ? 32'h1 : 32'h0);
      chk("t2_hold_pc", pc_out, 32'h8);
    end
    chk("t2_addr", imem_addr, 32'h18);
    stall = 1'b0;
    repeat (8) step();
    chk("t2_resume_valid", inst_valid, 32'h1);
    chk("t2_resume_pc", pc_out, 32'h28);

    // 3: latency 3, two outstanding, redirect drops both late responses
    do_reset(3);
    imem_ready = 1'b1;
    step();
    step();
    imem_ready = 1'b0;
    chk("t3_addr", imem_addr, 32'h8);
    jb = 1'b1;
    jb_target = 32'h100;
    #1;
    chk("t3_req_jb", imem_req, 32'h0);
    step();
    jb = 1'b0;
    imem_ready = 1'b1;
    chk("t3_addr_redirect", imem_addr, 32'h100);
    chk("t3_empty", inst_valid, 32'h0);
    wait_valid("t3", 20, n);
    chk("t3_wait", n, 32'd4);
    chk("t3_pc", pc_out, 32'h100);
    chk("t3_inst", inst_out, inst_of(32'h100));

    // 4: redirect coinciding with a response and a would-be pop
    do_reset(1);
    imem_ready = 1'b1;
    repeat (4) step();
    jb = 1'b1;
    jb_target = 32'h203;
    #1;
    chk("t4_pre_valid", inst_valid, 32'h1);
    chk("t4_req_jb", imem_req, 32'h0);
    step();
    jb = 1'b0;
    chk("t4_flushed", inst_valid, 32'h0);
    chk("t4_if_empty", if_empty, 32'h1);
    chk("t4_pc_bubble", pc_out, 32'h0);
    chk("t4_addr", imem_addr, 32'h200);
    wait_valid("t4", 10, n);
    chk("t4_wait", n, 32'd2);
    chk("t4_pc", pc_out, 32'h200);

    // 5: memory not ready holds the address; FIFO drains to a bubble
    do_reset(1);
    imem_ready = 1'b1;
    repeat (4) step();
    chk("t5_addr_pre", imem_addr, 32'h10);
    imem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("t5_addr_hold", imem_addr, 32'h10);
      chk("t5_req_hold", imem_req, 32'h1);
    end
    chk("t5_valid", inst_valid, 32'h0);
    chk("t5_pc", pc_out, 32'h0);
    chk("t5_inst", inst_out, 32'h0);
    chk("t5_if_empty", if_empty, 32'h1);
    imem_ready = 1'b1;
    wait_valid("t5", 10, n);
    chk("t5_wait", n, 32'd2);
    chk("t5_resume_pc", pc_out, 32'h10);

    // 6: reset with three requests in flight, then restart from RESET_PC
    do_reset(3);
    imem_ready = 1'b1;
    repeat (4) step();
    chk("t6_inflight", 32'(mem_q.size()), 32'd3);
    chk("t6_pre_valid", inst_valid, 32'h1);
    do_reset(1);
    imem_ready = 1'b1;
    chk("t6_restart_addr", imem_addr, 32'h0);
    step();
    step();
    chk("t6_restart_valid", inst_valid, 32'h1);
    chk("t6_restart_pc", pc_out, 32'h0);
    chk("t6_restart_inst", inst_out, inst_of(32'h0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
